// File: rtl/rs232_loader_pkg.sv
// rtl/rs232_loader_pkg.sv - shared states and protocol constants for the RS232 burst loader
// CSUM state exists only when RS232_LOADER_CHECKSUM_EN is defined.
package rs232_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    WRITE,
`ifdef RS232_LOADER_CHECKSUM_EN
    CSUM,
`endif
    ACK
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] ACK_OK    = 8'hA5;
  localparam logic [7:0] ACK_ERR   = 8'h5A;

endpackage

// File: rtl/rs232_byte_packer.sv
// rtl/rs232_byte_packer.sv - shifts NBYTES bytes in MSB-first, flags the final byte
module rs232_byte_packer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift,
  input  logic [7:0]            din,
  output logic [8*NBYTES-1:0]   data,
  output logic                  done
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8*NBYTES-1:0]   data_q, data_d;
  logic [8*NBYTES+7:0]   shifted;

  // done is combinational so the caller can change state on the same edge the last byte lands
  always_comb begin
    shifted = {data_q, din};
    data_d  = data_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (shift) begin
      data_d = shifted[8*NBYTES-1:0];
      if (cnt_q == LAST) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/rs232_burst_loader.sv
// rtl/rs232_burst_loader.sv - UART command parser issuing burst memory writes and an ack byte
// Optional running-XOR checksum stage enabled by RS232_LOADER_CHECKSUM_EN.
module rs232_burst_loader
  import rs232_loader_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 4,
  parameter int PTR_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [7:0]              oInfobyte,
  output logic [8*DATA_BYTES-1:0] dout,
  output logic [8*ADDR_BYTES-1:0] addr_out,
  output logic                    we,
  output logic [7:0]              iData_RS232,
  output logic                    WriteEnable_RS232,
  input  logic                    oWrBuffer_full_RS232,
  input  logic [7:0]              oData_RS232,
  output logic [PTR_W-1:0]        read_addr_RS232,
  input  logic [PTR_W-1:0]        rx_addr_RS232
);

  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [5:0]        burst_q, burst_d;
  logic              consume, addr_done, data_done;
  logic [AW-1:0]     addr_pk;
  logic [DW-1:0]     data_pk;
  logic              csum_err;
`ifdef RS232_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
  logic              err_q, err_d;
  assign csum_err = err_q;
`else
  assign csum_err = 1'b0;
`endif

  always_comb begin
    consume = 1'b0;
    if (enable && (rd_ptr_q != rx_addr_RS232)) begin
      case (state_q)
        IDLE, ADDR, LEN, DATA: consume = 1'b1;
`ifdef RS232_LOADER_CHECKSUM_EN
        CSUM:                  consume = 1'b1;
`endif
        default:               consume = 1'b0;
      endcase
    end
  end

  rs232_byte_packer #(.NBYTES(ADDR_BYTES)) u_addr_pk (
    .clk(clk), .rst_n(rst), .shift(consume && (state_q == ADDR)),
    .din(oData_RS232), .data(addr_pk), .done(addr_done)
  );

  rs232_byte_packer #(.NBYTES(DATA_BYTES)) u_data_pk (
    .clk(clk), .rst_n(rst), .shift(consume && (state_q == DATA)),
    .din(oData_RS232), .data(data_pk), .done(data_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
`ifdef RS232_LOADER_CHECKSUM_EN
      xor_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
`ifdef RS232_LOADER_CHECKSUM_EN
      xor_q    <= xor_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(consume);
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
`ifdef RS232_LOADER_CHECKSUM_EN
    xor_d    = xor_q;
    err_d    = err_q;
    if (consume && (state_q != IDLE) && (state_q != CSUM)) xor_d = xor_q ^ oData_RS232;
`endif
    case (state_q)
      IDLE: if (consume && (oData_RS232 == CMD_WRITE)) begin
        state_d = ADDR;
`ifdef RS232_LOADER_CHECKSUM_EN
        xor_d   = CMD_WRITE;
`endif
      end
      ADDR: if (addr_done) state_d = LEN;
      // the address packer is complete by now; latch it so WRITE can increment a private copy
      LEN: if (consume) begin
        addr_d  = addr_pk;
        cnt_d   = (oData_RS232 == 8'h00) ? 9'd256 : {1'b0, oData_RS232};
        state_d = DATA;
      end
      DATA: if (data_done) state_d = WRITE;
      WRITE: if (enable) begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 9'd1;
`ifdef RS232_LOADER_CHECKSUM_EN
        state_d = (cnt_q == 9'd1) ? CSUM : DATA;
`else
        state_d = (cnt_q == 9'd1) ? ACK : DATA;
`endif
      end
`ifdef RS232_LOADER_CHECKSUM_EN
      CSUM: if (consume) begin
        err_d   = (oData_RS232 != xor_q);
        state_d = ACK;
      end
`endif
      ACK: if (enable && !oWrBuffer_full_RS232) begin
        burst_d = burst_q + 6'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we                = (state_q == WRITE) && enable;
    WriteEnable_RS232 = (state_q == ACK) && enable && !oWrBuffer_full_RS232;
    iData_RS232       = 8'h00;
    if (state_q == ACK) iData_RS232 = csum_err ? ACK_ERR : ACK_OK;
    oInfobyte         = {(state_q != IDLE), csum_err, burst_q};
    dout              = data_pk;
    addr_out          = addr_q;
    read_addr_RS232   = rd_ptr_q;
  end

endmodule

// File: doc/rs232_burst_loader.md
RS232_BURST_LOADER -- requirements
Module: rs232_burst_loader

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4: bytes per memory word; dout width = 8*DATA_BYTES.
REQ-002 SHALL have parameter ADDR_BYTES, default 4: address bytes per command; addr_out width = 8*ADDR_BYTES.
REQ-003 SHALL have parameter PTR_W, default 3: width of the UART FIFO pointers.
REQ-004 SHALL have port clk, in, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, in, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, in, 1: when high, the block advances; when low, all state holds.
REQ-007 SHALL have port oInfobyte, out, 8: status, defined as [7]=busy, [6]=last checksum error, [5:0]=completed-burst count.
REQ-008 SHALL have port dout, out, 8*DATA_BYTES: write data.
REQ-009 SHALL have port addr_out, out, 8*ADDR_BYTES: write word address.
REQ-010 SHALL have port we, out, 1: one-cycle write strobe.
REQ-011 SHALL have port iData_RS232, out, 8: byte to the UART transmit buffer.
REQ-012 SHALL have port WriteEnable_RS232, out, 1: one-cycle transmit push.
REQ-013 SHALL have port oWrBuffer_full_RS232, in, 1: transmit buffer full.
REQ-014 SHALL have port oData_RS232, in, 8: receive FIFO byte at read_addr_RS232.
REQ-015 SHALL have port read_addr_RS232, out, PTR_W: receive FIFO read pointer, owned by this block.
REQ-016 SHALL have port rx_addr_RS232, in, PTR_W: receive FIFO write pointer.

Function
REQ-017 SHALL treat a byte as available when read_addr_RS232 != rx_addr_RS232, and consume at most one byte per cycle by incrementing read_addr_RS232 (wraps modulo 2^PTR_W).
REQ-018 SHALL implement states IDLE, ADDR, LEN, DATA, WRITE, CSUM, ACK.
REQ-019 IDLE: consume bytes; 0x57 -> ADDR; any other byte is discarded, state stays IDLE.
REQ-020 ADDR: consume ADDR_BYTES bytes MSB-first into the address register -> LEN.
REQ-021 LEN: consume one byte as word count N, with 0 meaning 256 -> DATA.
REQ-022 DATA: consume DATA_BYTES bytes MSB-first into dout; after the last byte -> WRITE.
REQ-023 WRITE: assert we for exactly one cycle with stable dout/addr_out, consume no byte, then increment address by 1 (wraps at 2^(8*ADDR_BYTES)).
REQ-024 WRITE exit: decrement remaining count; if words remain -> DATA, else -> CSUM if configured, else ACK.
REQ-025 ACK: hold while oWrBuffer_full_RS232=1; otherwise pulse WriteEnable_RS232 for one cycle with iData_RS232=0xA5 (ok) or 0x5A (checksum error), increment burst count (mod 64) -> IDLE.
REQ-026 While enable=0: no byte consumed, no we, no WriteEnable_RS232, registers hold; operation resumes exactly where stalled.
REQ-027 Empty FIFO in any consuming state: wait, no timeout.
REQ-028 oInfobyte[7] SHALL be 1 in every state except IDLE.

Reset
REQ-029 On rst low, immediately: state=IDLE, read_addr_RS232=0, dout=0, addr_out=0, we=0, iData_RS232=0, WriteEnable_RS232=0, oInfobyte=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no further we and no ack.

Configuration
REQ-031 With macro RS232_LOADER_CHECKSUM_EN defined: the block keeps a running XOR of all bytes from 0x57 through the last data byte; CSUM consumes one byte; mismatch sets oInfobyte[6] and selects 0x5A, match clears [6]; the checksum byte is consumed even if mismatched; writes already issued are not rolled back.
REQ-032 Without RS232_LOADER_CHECKSUM_EN: no CSUM state, no XOR logic, ack always 0xA5, oInfobyte[6] constant 0.

Structure
REQ-033 Package rs232_loader_pkg SHALL hold the state enum, CMD_WRITE=0x57, ACK_OK=0xA5, ACK_ERR=0x5A.
REQ-034 Sub-module rs232_byte_packer (shift-in of N bytes MSB-first with done flag) SHALL be used for both address and data assembly.

Verification
REQ-035 Defaults; stream 57 00 00 01 00 01 DE AD BE EF -> one we with addr_out=0x00000100, dout=0xDEADBEEF; then ack 0xA5; oInfobyte=0x01.
REQ-036 LEN=00 with 256 words -> exactly 256 we pulses, addresses base..base+255, count wraps correctly.
REQ-037 Leading bytes 11 22 then a valid command -> junk ignored, single burst is correct.
REQ-038 Hold oWrBuffer_full_RS232=1 for 10 cycles at ACK -> no WriteEnable_RS232 until released, then exactly one pulse.
REQ-039 enable=0 mid-DATA for 5 cycles with bytes pending -> read_addr_RS232 frozen, dout intact, correct we after resume.
REQ-040 Checksum on, bad checksum byte -> we pulses still issued, ack 0x5A, oInfobyte[6]=1; following good burst clears [6]; assert rst mid-DATA -> outputs zero, no ack.
